// File: rtl/npc_pkg.sv
// Shared definitions for the write-back unit: datapath width, GPR count and FSM state type.
package npc_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NR_REGS = 32;
    localparam int unsigned RIDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wbu_state_t;

    // Retire counter step; wraps naturally at 32 bits.
    function automatic logic [31:0] retire_inc(input logic [31:0] cnt);
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero. Reads during a write return the old contents (no bypass).
module regfile #(
    parameter int unsigned XLEN    = npc_pkg::XLEN,
    parameter int unsigned NR_REGS = npc_pkg::NR_REGS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [npc_pkg::RIDX_W-1:0]    waddr,
    input  logic [XLEN-1:0]               wdata,
    input  logic [npc_pkg::RIDX_W-1:0]    raddr1,
    input  logic [npc_pkg::RIDX_W-1:0]    raddr2,
    output logic [XLEN-1:0]               rdata1,
    output logic [XLEN-1:0]               rdata2
);
    import npc_pkg::*;

    logic [XLEN-1:0] regs_q [NR_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NR_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule

// File: rtl/wbu.sv
// Write-back unit: latches a finished instruction, waits for memory if needed,
// then commits to the GPR file for one cycle and pulses retire to the IFU.
module wbu #(
    parameter int unsigned XLEN    = npc_pkg::XLEN,
    parameter int unsigned NR_REGS = npc_pkg::NR_REGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wbu_receive_valid,
    input  logic             reg_wen,
    input  logic [4:0]       rd,
    input  logic             ren,
    input  logic             wen,
    input  logic [XLEN-1:0]  exu_result,
    input  logic             lsu_send_valid,
    input  logic [XLEN-1:0]  memory_read_wd,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wbu_send_valid,
    output logic [31:0]      retire_cnt,
    output logic             wbu_busy
);
    import npc_pkg::*;

    wbu_state_t      state_q, state_d;
    logic            reg_wen_q, ren_q, wen_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] exu_result_q, load_data_q;
    logic [31:0]     retire_cnt_q, retire_cnt_d;

    logic            accept;
    logic            mem_done;
    logic            commit;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        mem_done       = 1'b0;
        commit         = 1'b0;
        wbu_busy       = 1'b0;
        wbu_send_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wbu_receive_valid) begin
                    accept  = 1'b1;
                    state_d = (ren || wen) ? WAIT_MEM : COMMIT;
                end
            end
            WAIT_MEM: begin
                wbu_busy = 1'b1;
                if (lsu_send_valid) begin
                    mem_done = 1'b1;
                    state_d  = COMMIT;
                end
            end
            COMMIT: begin
                wbu_busy       = 1'b1;
                wbu_send_valid = 1'b1;
                commit         = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit) begin
            retire_cnt_d = retire_inc(retire_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            reg_wen_q    <= 1'b0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            rd_q         <= '0;
            exu_result_q <= '0;
            load_data_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
            if (accept) begin
                reg_wen_q    <= reg_wen;
                ren_q        <= ren;
                wen_q        <= wen;
                rd_q         <= rd;
                exu_result_q <= exu_result;
            end
            if (mem_done && ren_q) begin
                load_data_q <= memory_read_wd;
            end
        end
    end

    // A pure store never writes rd, even if reg_wen was set alongside it.
    assign rf_we    = commit && reg_wen_q && (rd_q != 5'd0) && !(wen_q && !ren_q);
    assign rf_wdata = ren_q ? load_data_q : exu_result_q;

    assign retire_cnt = retire_cnt_q;

    regfile #(
        .XLEN    (XLEN),
        .NR_REGS (NR_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rd_q),
        .wdata  (rf_wdata),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_wbu.sv
// Directed testbench for wbu: inputs driven and outputs checked on the falling clock edge.
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbu_receive_valid;
    logic        reg_wen;
    logic [4:0]  rd;
    logic        ren;
    logic        wen;
    logic [31:0] exu_result;
    logic        lsu_send_valid;
    logic [31:0] memory_read_wd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wbu_send_valid;
    logic [31:0] retire_cnt;
    logic        wbu_busy;

    int vectors    = 0;
    int miscompares = 0;
    int pulses;

    always #5 clk = ~clk;

    wbu dut (
        .clk               (clk),
        .rst               (rst),
        .wbu_receive_valid (wbu_receive_valid),
        .reg_wen           (reg_wen),
        .rd                (rd),
        .ren               (ren),
        .wen               (wen),
        .exu_result        (exu_result),
        .lsu_send_valid    (lsu_send_valid),
        .memory_read_wd    (memory_read_wd),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .wbu_send_valid    (wbu_send_valid),
        .retire_cnt        (retire_cnt),
        .wbu_busy          (wbu_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [4:0] dst, input logic ld, input logic st,
                         input logic [31:0] res);
        wbu_receive_valid = 1'b1;
        reg_wen           = wr;
        rd                = dst;
        ren               = ld;
        wen               = st;
        exu_result        = res;
    endtask

    task automatic idle_inputs();
        wbu_receive_valid = 1'b0;
        reg_wen           = 1'b0;
        rd                = 5'd0;
        ren               = 1'b0;
        wen               = 1'b0;
        exu_result        = 32'h0;
        lsu_send_valid    = 1'b0;
        memory_read_wd    = 32'h0;
    endtask

    initial begin
        rst      = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        idle_inputs();
        step();
        step();

        // Reset state
        rs1_addr = 5'd5;
        #1;
        chk("rst_busy", {31'b0, wbu_busy}, 32'd0);
        chk("rst_send", {31'b0, wbu_send_valid}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_gpr5", rs1_data, 32'd0);
        rst = 1'b0;
        step();

        // ALU op to x5, retire the next cycle
        issue(1'b1, 5'd5, 1'b0, 1'b0, 32'h1234_5678);
        step();
        idle_inputs();
        chk("alu_send", {31'b0, wbu_send_valid}, 32'd1);
        chk("alu_busy", {31'b0, wbu_busy}, 32'd1);
        chk("alu_nobypass", rs1_data, 32'd0);
        step();
        chk("alu_send_end", {31'b0, wbu_send_valid}, 32'd0);
        chk("alu_gpr5", rs1_data, 32'h1234_5678);
        chk("alu_cnt", retire_cnt, 32'd1);

        // Load to x7; an lsu_send_valid in the entry cycle must be ignored
        rs2_addr = 5'd7;
        issue(1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_0100);
        lsu_send_valid = 1'b1;
        memory_read_wd = 32'h1111_1111;
        step();
        idle_inputs();
        chk("ld_wait_busy", {31'b0, wbu_busy}, 32'd1);
        chk("ld_wait_send0", {31'b0, wbu_send_valid}, 32'd0);
        step();
        chk("ld_wait_send1", {31'b0, wbu_send_valid}, 32'd0);
        step();
        chk("ld_wait_send2", {31'b0, wbu_send_valid}, 32'd0);
        lsu_send_valid = 1'b1;
        memory_read_wd = 32'hFFFF_FF80;
        step();
        idle_inputs();
        chk("ld_send", {31'b0, wbu_send_valid}, 32'd1);
        chk("ld_nobypass", rs2_data, 32'd0);
        step();
        chk("ld_send_end", {31'b0, wbu_send_valid}, 32'd0);
        chk("ld_gpr7", rs2_data, 32'hFFFF_FF80);
        chk("ld_cnt", retire_cnt, 32'd2);

        // Seed x3, then a store naming rd=3 must leave it untouched
        rs1_addr = 5'd3;
        issue(1'b1, 5'd3, 1'b0, 1'b0, 32'h3333_3333);
        step();
        idle_inputs();
        step();
        chk("seed_gpr3", rs1_data, 32'h3333_3333);
        issue(1'b0, 5'd3, 1'b0, 1'b1, 32'hAAAA_0000);
        step();
        idle_inputs();
        chk("st_wait", {31'b0, wbu_send_valid}, 32'd0);
        lsu_send_valid = 1'b1;
        memory_read_wd = 32'h5555_5555;
        step();
        idle_inputs();
        chk("st_send", {31'b0, wbu_send_valid}, 32'd1);
        step();
        chk("st_send_end", {31'b0, wbu_send_valid}, 32'd0);
        chk("st_gpr3", rs1_data, 32'h3333_3333);
        chk("st_cnt", retire_cnt, 32'd4);

        // Write to x0 is discarded but still retires
        rs1_addr = 5'd0;
        issue(1'b1, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        step();
        idle_inputs();
        chk("x0_send", {31'b0, wbu_send_valid}, 32'd1);
        step();
        chk("x0_read", rs1_data, 32'd0);
        chk("x0_cnt", retire_cnt, 32'd5);

        // Reset while a load to x9 waits for memory
        rs1_addr = 5'd9;
        rs2_addr = 5'd5;
        issue(1'b1, 5'd9, 1'b1, 1'b0, 32'h0000_0200);
        step();
        idle_inputs();
        chk("rstw_busy", {31'b0, wbu_busy}, 32'd1);
        rst = 1'b1;
        lsu_send_valid = 1'b1;
        memory_read_wd = 32'hCAFE_F00D;
        step();
        rst = 1'b0;
        idle_inputs();
        chk("rstw_busy0", {31'b0, wbu_busy}, 32'd0);
        chk("rstw_send0", {31'b0, wbu_send_valid}, 32'd0);
        chk("rstw_cnt", retire_cnt, 32'd0);
        chk("rstw_gpr9", rs1_data, 32'd0);
        chk("rstw_gpr5", rs2_data, 32'd0);
        lsu_send_valid = 1'b1;
        memory_read_wd = 32'hCAFE_F00D;
        step();
        idle_inputs();
        chk("rstw_late_send", {31'b0, wbu_send_valid}, 32'd0);
        chk("rstw_late_busy", {31'b0, wbu_busy}, 32'd0);
        step();
        chk("rstw_late_send2", {31'b0, wbu_send_valid}, 32'd0);
        chk("rstw_late_gpr9", rs1_data, 32'd0);

        // Counter wrap, with a second receive ignored while in WAIT_MEM
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        step();
        step();
        release dut.retire_cnt_q;
        step();
        chk("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        rs1_addr = 5'd10;
        rs2_addr = 5'd11;
        pulses   = 0;
        issue(1'b1, 5'd10, 1'b1, 1'b0, 32'h0000_0300);
        step();
        issue(1'b1, 5'd11, 1'b0, 1'b0, 32'h0BAD_0BAD);
        if (wbu_send_valid) pulses++;
        step();
        if (wbu_send_valid) pulses++;
        lsu_send_valid = 1'b1;
        memory_read_wd = 32'h0000_00AB;
        step();
        idle_inputs();
        if (wbu_send_valid) pulses++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wbu_send_valid) pulses++;
        end
        chk("wrap_pulses", pulses, 32'd1);
        chk("wrap_cnt", retire_cnt, 32'd0);
        chk("wrap_gpr10", rs1_data, 32'h0000_00AB);
        chk("wrap_gpr11", rs2_data, 32'd0);
        chk("wrap_idle", {31'b0, wbu_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 Parameter XLEN, default 32, data/register width.
REQ-002 Parameter NR_REGS, default 32, architectural GPR count.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
REQ-004 Port list:
- wbu_receive_valid  in  1  EXU done with current instruction; operands below valid this cycle.
- reg_wen  in  1  instruction writes rd.
- rd  in  5  destination register index.
- ren  in  1  instruction is a load.
- wen  in  1  instruction is a store.
- exu_result  in  XLEN  ALU result or effective address.
- lsu_send_valid  in  1  LSU access complete.
- memory_read_wd  in  XLEN  extended load data, valid with lsu_send_valid.
- rs1_addr, rs2_addr  in  5 each  register read indices.
- rs1_data, rs2_data  out  XLEN each  combinational register read data.
- wbu_send_valid  out  1  one-cycle retire pulse to IFU.
- retire_cnt  out  32  retired-instruction count.
- wbu_busy  out  1  high in any state other than IDLE.

Function
REQ-005 FSM states IDLE, WAIT_MEM, COMMIT.
REQ-006 IDLE + wbu_receive_valid: latch reg_wen, rd, ren, wen, exu_result; go to WAIT_MEM if ren|wen, otherwise to COMMIT.
REQ-007 IDLE without wbu_receive_valid: stay in IDLE.
REQ-008 WAIT_MEM + lsu_send_valid: latch memory_read_wd when the latched ren is set, then go to COMMIT.
REQ-009 WAIT_MEM without lsu_send_valid: stay; no timeout.
REQ-010 COMMIT: for one cycle, write the latched data to GPR[rd] when latched reg_wen=1 and rd!=0; then go to IDLE.
REQ-011 Write data is the latched load data when latched ren=1, otherwise the latched exu_result.
REQ-012 Store (wen=1, ren=0): the store result is not written back to GPR[rd].
REQ-013 wbu_send_valid is high exactly during the COMMIT cycle; low otherwise.
REQ-014 retire_cnt increments by 1 at the end of each COMMIT cycle; wraps 0xFFFFFFFF -> 0.
REQ-015 wbu_receive_valid is ignored outside IDLE; no queuing.
REQ-016 lsu_send_valid is ignored outside WAIT_MEM.
REQ-017 GPR[0] always reads 0; writes to it are discarded.
REQ-018 Reads are combinational; a read in the COMMIT cycle returns the old value, with no bypass.
REQ-019 Latency, non-memory op: wbu_receive_valid at cycle N -> wbu_send_valid at N+1.
REQ-020 Latency, memory op: lsu_send_valid at cycle M (in WAIT_MEM) -> wbu_send_valid at M+1.
REQ-021 lsu_send_valid and wbu_receive_valid arriving in the same cycle as the entry to WAIT_MEM: lsu_send_valid is ignored that cycle.

Reset
REQ-022 On rst: state=IDLE; wbu_send_valid=0; wbu_busy=0; retire_cnt=0; all GPRs=0; all latches=0.
REQ-023 rst in WAIT_MEM or COMMIT abandons the instruction: no GPR write, no retire pulse, counter cleared.
REQ-024 Reset has priority over every other event in the same cycle.

Structure
REQ-025 Shared package npc_pkg holds XLEN, the GPR count, and the wbu_state_t enum (IDLE, WAIT_MEM, COMMIT).
REQ-026 One sub-module, regfile: NR_REGS x XLEN, two combinational read ports, one synchronous write port, x0 hardwired to 0.
REQ-027 The FSM, latches and retire counter live in wbu.

Verification
REQ-028 ALU op: reg_wen=1, rd=5, exu_result=0x12345678, receive_valid pulse -> send_valid the next cycle; rs1_addr=5 reads 0x12345678 afterwards; retire_cnt=1.
REQ-029 Load: ren=1, rd=7; lsu_send_valid after 3 cycles with data 0xFFFFFF80 -> GPR7=0xFFFFFF80; send_valid exactly one cycle after lsu_send_valid.
REQ-030 Store: wen=1, reg_wen=0, rd=3 -> GPR3 unchanged; one retire pulse after lsu_send_valid.
REQ-031 Write to x0 with exu_result=0xDEADBEEF -> rs1_addr=0 reads 0; retire_cnt still increments.
REQ-032 rst asserted in WAIT_MEM with a load to rd=9 pending -> GPR9=0; no send_valid; retire_cnt=0; a later lsu_send_valid is ignored.
REQ-033 Second wbu_receive_valid while in WAIT_MEM is ignored -> exactly one retire; preload retire_cnt=0xFFFFFFFF, one retire -> retire_cnt=0.
